// File: rtl/custom_acc_core_pkg.sv
// custom_acc_core_pkg
// Shared definitions for the dot-product accelerator core: width constants,
// the controller state encoding, operand generators and the result saturator.
package custom_acc_core_pkg;

  localparam int SHORT = 15;  // MSB of 16-bit quantities (index, counters)
  localparam int INT   = 31;  // MSB of 32-bit quantities (operands, result)
  localparam int LONG  = 63;  // MSB of 64-bit quantities (accumulator)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturation bounds, sign-extended to accumulator width.
  localparam logic signed [LONG:0] SAT_MAX = {{(LONG - INT + 1){1'b0}}, {INT{1'b1}}};
  localparam logic signed [LONG:0] SAT_MIN = {{(LONG - INT + 1){1'b1}}, {INT{1'b0}}};

  // a[k] = k + 1
  function automatic logic signed [INT:0] op_a(input logic [SHORT:0] k);
    return $signed({{(INT - SHORT){1'b0}}, k}) + 32'sd1;
  endfunction

  // b[k] = len - k
  function automatic logic signed [INT:0] op_b(input logic [SHORT:0] k,
                                               input logic [SHORT:0] len);
    return $signed({{(INT - SHORT){1'b0}}, len}) - $signed({{(INT - SHORT){1'b0}}, k});
  endfunction

  // Clamp the accumulator into the signed 32-bit result range.
  function automatic logic signed [INT:0] sat(input logic signed [LONG:0] v);
    if (v > SAT_MAX)      return {1'b0, {INT{1'b1}}};
    else if (v < SAT_MIN) return {1'b1, {INT{1'b0}}};
    else                  return v[INT:0];
  endfunction

endpackage

// File: rtl/custom_acc_core_mac.sv
// acc_mac
// Signed 32x32 multiplier feeding a 64-bit accumulator register.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   clear  synchronous accumulator clear (wins over en)
//   en     add a*b into the accumulator this cycle
//   a, b   signed operands
//   acc    signed accumulator value
module acc_mac
  import custom_acc_core_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   en,
  input  logic signed [INT:0]    a,
  input  logic signed [INT:0]    b,
  output logic signed [LONG:0]   acc
);

  logic signed [LONG:0] a_ext;
  logic signed [LONG:0] b_ext;
  logic signed [LONG:0] prod;

  // Sign-extend first so the multiply is carried out at full 64-bit width.
  assign a_ext = {{(LONG - INT){a[INT]}}, a};
  assign b_ext = {{(LONG - INT){b[INT]}}, b};
  assign prod  = a_ext * b_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= acc + prod;
  end

endmodule

// File: rtl/custom_acc_core.sv
// custom_acc_core
// Fixed-function dot-product engine: on a rising edge of i_start it
// accumulates sum(a[k]*b[k]) for k = 0..LEN-1 over internally generated
// operands, then pulses o_finish for one cycle and presents the saturated
// result on o_result (held until the next completion).
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   i_start   start request, rising-edge sensitive
//   o_finish  one-cycle completion pulse
//   o_busy    high while MACs are in progress
//   o_result  signed saturated result of the last completed run
//
// state | meaning
// IDLE  | waiting for a start rising edge
// RUN   | one MAC per cycle, idx 0..LEN-1
// DONE  | accumulator final; result captured and finish pulsed next edge
module custom_acc_core #(
  parameter int LEN   = 16,
  parameter int SHORT = custom_acc_core_pkg::SHORT,
  parameter int INT   = custom_acc_core_pkg::INT,
  parameter int LONG  = custom_acc_core_pkg::LONG
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  output logic                o_finish,
  output logic                o_busy,
  output logic signed [INT:0] o_result
);
  import custom_acc_core_pkg::*;

  localparam logic [SHORT:0] LEN_V = (SHORT + 1)'(LEN);
  localparam logic [SHORT:0] LAST  = (SHORT + 1)'(LEN - 1);

  state_t               state_q;
  state_t               state_d;
  logic                 start_d;
  logic                 trigger;
  logic [SHORT:0]       idx;
  logic                 acc_clear;
  logic                 acc_en;
  logic signed [LONG:0] acc;

  // start_d resets high so a start already asserted at reset release is
  // not mistaken for a fresh request.
  assign trigger = i_start & ~start_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      start_d <= 1'b1;
    end else begin
      state_q <= state_d;
      start_d <= i_start;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d   = RUN;
          acc_clear = 1'b1;
        end
      end
      RUN: begin
        acc_en = 1'b1;
        if (idx == LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          idx <= '0;
    else if (state_q == IDLE && trigger) idx <= '0;
    else if (state_q == RUN)             idx <= idx + 1'b1;
  end

  acc_mac u_mac (
    .clk   (clk),
    .reset (reset),
    .clear (acc_clear),
    .en    (acc_en),
    .a     (op_a(idx)),
    .b     (op_b(idx, LEN_V)),
    .acc   (acc)
  );

  // Busy follows the registered RUN state, so it drops on the edge that
  // enters DONE; finish and result follow one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_finish <= 1'b0;
      o_busy   <= 1'b0;
      o_result <= '0;
    end else begin
      o_finish <= (state_q == DONE);
      o_busy   <= (state_d == RUN);
      if (state_q == DONE) o_result <= sat(acc);
    end
  end

endmodule

// File: tb/tb_custom_acc_core.sv
module tb_custom_acc_core;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic reset;
  logic st16, st1, st4, st256;
  logic fin16, fin1, fin4, fin256;
  logic busy16, busy1, busy4, busy256;
  logic signed [31:0] res16, res1, res4, res256;

  custom_acc_core #(.LEN(16)) u16 (
    .clk(clk), .reset(reset), .i_start(st16),
    .o_finish(fin16), .o_busy(busy16), .o_result(res16));
  custom_acc_core #(.LEN(1)) u1 (
    .clk(clk), .reset(reset), .i_start(st1),
    .o_finish(fin1), .o_busy(busy1), .o_result(res1));
  custom_acc_core #(.LEN(4)) u4 (
    .clk(clk), .reset(reset), .i_start(st4),
    .o_finish(fin4), .o_busy(busy4), .o_result(res4));
  custom_acc_core #(.LEN(256)) u256 (
    .clk(clk), .reset(reset), .i_start(st256),
    .o_finish(fin256), .o_busy(busy256), .o_result(res256));

  int cyc = 0;
  int fin_total = 0;
  int busy_total = 0;
  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fin16)  fin_total  <= fin_total + 1;
    if (busy16) busy_total <= busy_total + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic get_fin(input int sel);
    case (sel)
      1:       return fin1;
      4:       return fin4;
      256:     return fin256;
      default: return fin16;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      1:       return busy1;
      4:       return busy4;
      256:     return busy256;
      default: return busy16;
    endcase
  endfunction

  function automatic logic signed [31:0] get_res(input int sel);
    case (sel)
      1:       return res1;
      4:       return res4;
      256:     return res256;
      default: return res16;
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      1:       st1   = v;
      4:       st4   = v;
      256:     st256 = v;
      default: st16  = v;
    endcase
  endtask

  // Waits on negedges for a finish pulse; reports whether and when it came.
  task automatic wait_fin(input int sel, input int budget, output bit seen, output int at);
    seen = 1'b0;
    at   = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (get_fin(sel) === 1'b1) begin
        seen = 1'b1;
        at   = cyc;
      end
    end
  endtask

  task automatic test_reset;
    int bad;
    reset = 1'b0;
    st16 = 1'b0; st1 = 1'b0; st4 = 1'b0; st256 = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (fin16 !== 1'b0 || busy16 !== 1'b0 || res16 !== 32'sd0) begin
      n_err++;
      $display("FAIL reset_values: finish=%b busy=%b result=%0d, want 0/0/0", fin16, busy16, res16);
    end
    @(negedge clk) reset = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (fin16 !== 1'b0 || busy16 !== 1'b0 || res16 !== 32'sd0 ||
          fin256 !== 1'b0 || busy1 !== 1'b0 || res4 !== 32'sd0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL idle_quiet: %0d cycles with nonzero outputs, want 0", bad);
    end
  endtask

  task automatic test_start_through_reset;
    int f0;
    @(negedge clk);
    reset = 1'b0;
    st16  = 1'b1;
    f0 = fin_total;
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    n_cmp++;
    if (fin_total - f0 != 0 || busy16 !== 1'b0) begin
      n_err++;
      $display("FAIL start_through_reset: finishes=%0d busy=%b, want 0/0", fin_total - f0, busy16);
    end
    st16 = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic;
    int f0, e0, at, exp;
    bit seen;
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    #50 st16 = 1'b1;
    exp_q.push_back(16 * 17 * 18 / 6);
    f0 = fin_total;
    @(posedge clk); #1 e0 = cyc;
    n_cmp++;
    if (busy16 !== 1'b1) begin
      n_err++;
      $display("FAIL basic_busy_rise: busy=%b after trigger edge, want 1", busy16);
    end
    #60 st16 = 1'b0;
    wait_fin(16, 40, seen, at);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL basic_finish: no finish pulse within budget, want one");
    end else begin
      n_cmp++;
      if (at - e0 != 17) begin
        n_err++;
        $display("FAIL basic_latency: finish %0d edges after trigger, want 17", at - e0);
      end
      n_cmp++;
      if (res16 !== exp) begin
        n_err++;
        $display("FAIL basic_result: result=%0d, want %0d", res16, exp);
      end
      n_cmp++;
      if (busy16 !== 1'b0) begin
        n_err++;
        $display("FAIL basic_busy_fall: busy=%b at finish, want 0", busy16);
      end
      @(negedge clk);
      n_cmp++;
      if (fin16 !== 1'b0) begin
        n_err++;
        $display("FAIL basic_pulse_width: finish=%b one cycle later, want 0", fin16);
      end
    end
    repeat (30) @(negedge clk);
    #1;
    n_cmp++;
    if (fin_total - f0 != 1) begin
      n_err++;
      $display("FAIL basic_pulse_count: %0d finish cycles, want 1", fin_total - f0);
    end
  endtask

  task automatic test_start_held;
    int f0, b0, exp;
    @(negedge clk);
    f0 = fin_total;
    b0 = busy_total;
    st16 = 1'b1;
    exp_q.push_back(816);
    repeat (100) @(negedge clk);
    st16 = 1'b0;
    #1;
    exp = exp_q.pop_front();
    n_cmp++;
    if (fin_total - f0 != 1) begin
      n_err++;
      $display("FAIL held_finish_count: %0d finish cycles, want 1", fin_total - f0);
    end
    n_cmp++;
    if (busy_total - b0 != 16) begin
      n_err++;
      $display("FAIL held_busy_cycles: busy for %0d cycles, want 16", busy_total - b0);
    end
    n_cmp++;
    if (res16 !== exp) begin
      n_err++;
      $display("FAIL held_result: result=%0d, want %0d", res16, exp);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int f0, t1, at, exp;
    bit seen;
    @(negedge clk);
    f0 = fin_total;
    st16 = 1'b1;
    exp_q.push_back(816);
    @(negedge clk) st16 = 1'b0;
    repeat (5) @(negedge clk);
    st16 = 1'b1;                      // during RUN: must be ignored
    @(negedge clk) st16 = 1'b0;
    wait_fin(16, 40, seen, at);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!seen || res16 !== exp) begin
      n_err++;
      $display("FAIL b2b_first: seen=%0d result=%0d, want 1/%0d", seen, res16, exp);
    end
    st16 = 1'b1;                      // right after the finish pulse
    exp_q.push_back(816);
    t1 = cyc + 1;
    @(negedge clk) st16 = 1'b0;
    wait_fin(16, 40, seen, at);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL b2b_second: no second finish pulse, want one");
    end else begin
      n_cmp++;
      if (at - t1 != 17 || res16 !== exp) begin
        n_err++;
        $display("FAIL b2b_second_run: latency=%0d result=%0d, want 17/%0d", at - t1, res16, exp);
      end
    end
    repeat (20) @(negedge clk);
    #1;
    n_cmp++;
    if (fin_total - f0 != 2) begin
      n_err++;
      $display("FAIL b2b_run_count: %0d finish cycles, want 2", fin_total - f0);
    end
  endtask

  task automatic test_reset_mid_run;
    int f0, at, exp;
    bit seen;
    @(negedge clk);
    f0 = fin_total;
    st16 = 1'b1;
    @(posedge clk); #1 st16 = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (busy16 !== 1'b0 || res16 !== 32'sd0 || fin16 !== 1'b0) begin
      n_err++;
      $display("FAIL midrun_reset: busy=%b result=%0d finish=%b, want 0/0/0", busy16, res16, fin16);
    end
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    n_cmp++;
    if (fin_total - f0 != 0) begin
      n_err++;
      $display("FAIL midrun_no_finish: %0d finish cycles, want 0", fin_total - f0);
    end
    @(negedge clk) st16 = 1'b1;
    exp_q.push_back(816);
    @(negedge clk) st16 = 1'b0;
    wait_fin(16, 40, seen, at);
    exp = exp_q.pop_front();
    n_cmp++;
    if (!seen || res16 !== exp) begin
      n_err++;
      $display("FAIL midrun_restart: seen=%0d result=%0d, want 1/%0d", seen, res16, exp);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_sweep;
    int lens[3];
    int exps[3];
    lens = '{1, 4, 256};
    exps = '{1, 20, 2829056};
    for (int n = 0; n < 3; n++) begin
      int  e0, at, exp;
      bit  seen;
      @(negedge clk) set_start(lens[n], 1'b1);
      exp_q.push_back(exps[n]);
      @(posedge clk); #1 e0 = cyc;
      n_cmp++;
      if (get_busy(lens[n]) !== 1'b1) begin
        n_err++;
        $display("FAIL sweep_busy LEN=%0d: busy=%b after trigger, want 1", lens[n], get_busy(lens[n]));
      end
      set_start(lens[n], 1'b0);
      wait_fin(lens[n], lens[n] + 40, seen, at);
      exp = exp_q.pop_front();
      n_cmp++;
      if (!seen) begin
        n_err++;
        $display("FAIL sweep_finish LEN=%0d: no finish pulse, want one", lens[n]);
      end else begin
        n_cmp++;
        if (at - e0 != lens[n] + 1) begin
          n_err++;
          $display("FAIL sweep_latency LEN=%0d: %0d edges, want %0d", lens[n], at - e0, lens[n] + 1);
        end
        n_cmp++;
        if (get_res(lens[n]) !== exp) begin
          n_err++;
          $display("FAIL sweep_result LEN=%0d: result=%0d, want %0d", lens[n], get_res(lens[n]), exp);
        end
      end
      repeat (3) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_start_through_reset();
    test_basic();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
